rate_tick_gen: RTL and testbench
================================

RATE_TICK_GEN -- requirements
Module: rate_tick_gen

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, sets the input clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, sets the number of stable cycles required to accept a button level (20 ms).
REQ-003 Port CLOCK_50, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port speed_sel, input, 2 bits: rate select; 00 = 1 Hz, 01 = 2 Hz, 10 = 4 Hz, 11 = 0.5 Hz.
REQ-006 Port pause_btn, input, 1 bit: raw, asynchronous, active-low push button that toggles run/pause.
REQ-007 Port tick, output, 1 bit: a one-cycle enable pulse that feeds the downstream digit counter.
REQ-008 Port running, output, 1 bit: 1 in RUN, 0 in PAUSE.

Function
REQ-009 Reload value SHALL be CLK_HZ-1, CLK_HZ/2-1, CLK_HZ/4-1 or 2*CLK_HZ-1 for speed_sel 00/01/10/11.
REQ-010 Down-counter width SHALL be $clog2(2*CLK_HZ); the counter never underflows.
REQ-011 In RUN with count==0, tick SHALL be 1 for exactly that cycle and the counter SHALL reload; otherwise, in RUN, the counter decrements.
REQ-012 The tick period SHALL therefore equal reload+1 cycles.
REQ-013 In PAUSE the counter SHALL hold its value and tick SHALL be 0.
REQ-014 On resume, counting SHALL continue from the held value, with no reload.
REQ-015 speed_sel SHALL be registered each cycle; when it differs from the registered value, the counter SHALL reload with the new value and tick SHALL be 0 in that cycle.
REQ-016 A speed change SHALL win over count==0 when both occur in the same cycle.
REQ-017 pause_btn SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-018 The debounced level SHALL change only after the synchronized level has held its new value for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the debounce count.
REQ-019 A 1-to-0 transition of the debounced level SHALL toggle the state (RUN <-> PAUSE) on the next cycle; a release SHALL have no effect.
REQ-020 If a toggle and count==0 coincide, the tick SHALL be issued according to the pre-toggle state.
REQ-021 The state machine SHALL have exactly two states, RUN and PAUSE, and no other transitions.

Reset
REQ-022 Reset SHALL force state RUN, running=1, tick=0, counter=reload(speed_sel), registered speed = speed_sel, synchronizer flops = 1, debounced level = 1 and debounce count = 0.
REQ-023 Reset asserted at any point, including mid-count, mid-debounce or in PAUSE, SHALL take effect on the next clock edge.

Configuration
REQ-024 With RATE_TICK_SINGLE_STEP_EN defined, the module SHALL add an input step_btn (1 bit, raw, active-low), synchronized and debounced identically to pause_btn.
REQ-025 Under RATE_TICK_SINGLE_STEP_EN, a debounced step_btn press in PAUSE SHALL produce exactly one tick on the following cycle and reload the counter.
REQ-026 Under RATE_TICK_SINGLE_STEP_EN, a step_btn press in RUN SHALL be ignored.
REQ-027 Without RATE_TICK_SINGLE_STEP_EN, the step_btn port and its logic SHALL be absent.

Structure
REQ-028 Package rate_tick_pkg SHALL hold the speed_sel encoding constants and the RUN/PAUSE state typedef.
REQ-029 Sub-module btn_debounce (synchronizer, debouncer and falling-edge pulse output) SHALL be instantiated once per button.

Verification
REQ-030 Benches SHALL use CLK_HZ=8 and DEBOUNCE_CYCLES=4.
REQ-031 Rate scenario: reset released with speed_sel=00 -> first tick 8 cycles later, then one tick every 8 cycles; speed_sel=10 -> every 2 cycles; speed_sel=11 -> every 16 cycles.
REQ-032 Speed-change scenario: switch 00 -> 01 at count 5 -> no tick in the change cycle; next tick exactly 4 cycles later.
REQ-033 Debounce scenario: 3-cycle low glitch on pause_btn -> running stays 1.
REQ-034 Pause scenario: pause_btn held low for 10 cycles -> running=0 and ticks stop with the counter held; a second press -> running=1 and the next tick arrives after the held count+1 cycles.
REQ-035 Reset scenario: reset asserted while in PAUSE mid-debounce -> next cycle running=1, tick=0, counter=reload.
REQ-036 With RATE_TICK_SINGLE_STEP_EN: in PAUSE, a step_btn press -> exactly one tick pulse; in RUN, a step_btn press -> tick cadence unchanged.

Source files
------------

// File: rtl/rate_tick_pkg.sv
// ----------------------------------------------------------------------------
// rate_tick_pkg
// Shared definitions for the rate tick generator:
//   - speed_sel encodings (1 Hz, 2 Hz, 4 Hz, 0.5 Hz)
//   - RUN/PAUSE state type
//   - reload_cycles(): down-counter reload value for a given speed and clock
// ----------------------------------------------------------------------------
package rate_tick_pkg;

    localparam logic [1:0] SPEED_1HZ    = 2'b00;
    localparam logic [1:0] SPEED_2HZ    = 2'b01;
    localparam logic [1:0] SPEED_4HZ    = 2'b10;
    localparam logic [1:0] SPEED_HALF_HZ = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } run_state_t;

    // Tick period is reload+1 cycles, so the reload is one less than the
    // number of clock cycles per tick at the selected rate.
    function automatic int unsigned reload_cycles(input logic [1:0]  sel,
                                                  input int unsigned clk_hz);
        int unsigned r;
        case (sel)
            SPEED_1HZ:     r = clk_hz - 1;
            SPEED_2HZ:     r = clk_hz / 2 - 1;
            SPEED_4HZ:     r = clk_hz / 4 - 1;
            SPEED_HALF_HZ: r = 2 * clk_hz - 1;
            default:       r = clk_hz - 1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, asynchronous, active-low push button:
//   2-flop synchronizer -> level debouncer -> registered press pulse.
// The debounced level follows the synchronized level only after the latter
// has held its new value for DEBOUNCE_CYCLES consecutive cycles; any bounce
// back to the current debounced level restarts the count.
//
// Ports
//   i_clk    : clock
//   i_srst   : synchronous active-high reset (sync flops and level -> 1)
//   i_btn_n  : raw button, active low, asynchronous to i_clk
//   o_fall   : one-cycle pulse in the cycle after the debounced level
//              falls 1 -> 0 (i.e. a press); releases produce nothing
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
)(
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_btn_n,
    output logic o_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fall;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                // Agrees with the accepted level: nothing pending.
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                r_level <= r_sync[1];
                r_cnt   <= '0;
                // The new level differs from r_level, so r_level==1 means 1->0.
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/rate_tick_gen.sv
// ----------------------------------------------------------------------------
// rate_tick_gen
// Produces a one-cycle enable pulse (tick) at 1, 2, 4 or 0.5 Hz for a
// downstream digit counter, with a debounced run/pause push button.
//
// Ports
//   CLOCK_50  : clock (frequency CLK_HZ)
//   reset     : synchronous active-high reset
//   speed_sel : 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=0.5 Hz
//   pause_btn : raw active-low button; each press toggles RUN/PAUSE
//   step_btn  : (only with RATE_TICK_SINGLE_STEP_EN) raw active-low button;
//               a press while paused emits exactly one tick
//   tick      : one-cycle enable pulse
//   running   : 1 in RUN, 0 in PAUSE
//
// Optional feature macro: RATE_TICK_SINGLE_STEP_EN (single-step button).
//
// tick is combinational from the counter/state so it appears in the very
// cycle the counter reads zero; it is forced low while reset is asserted and
// in any cycle where speed_sel differs from its registered copy.
// ----------------------------------------------------------------------------
module rate_tick_gen
    import rate_tick_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int          DEBOUNCE_CYCLES = 1_000_000
)(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] speed_sel,
    input  logic       pause_btn,
`ifdef RATE_TICK_SINGLE_STEP_EN
    input  logic       step_btn,
`endif
    output logic       tick,
    output logic       running
);

    localparam int CW        = $clog2(2 * CLK_HZ);
    localparam int BTN_PAUSE = 0;
`ifdef RATE_TICK_SINGLE_STEP_EN
    localparam int BTN_STEP  = 1;
    localparam int NUM_BTN   = 2;
`else
    localparam int NUM_BTN   = 1;
`endif

    // ------------------------------------------------------------------
    // Button conditioning: one debouncer per button
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_btn_raw_n;
    logic [NUM_BTN-1:0] w_btn_fall;

    assign w_btn_raw_n[BTN_PAUSE] = pause_btn;
`ifdef RATE_TICK_SINGLE_STEP_EN
    assign w_btn_raw_n[BTN_STEP]  = step_btn;
`endif

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .i_clk   (CLOCK_50),
                .i_srst  (reset),
                .i_btn_n (w_btn_raw_n[gi]),
                .o_fall  (w_btn_fall[gi])
            );
        end
    endgenerate

    logic w_pause_press;
    assign w_pause_press = w_btn_fall[BTN_PAUSE];

    // ------------------------------------------------------------------
    // Rate selection
    // ------------------------------------------------------------------
    logic [1:0]    r_speed;
    logic [CW-1:0] w_reload;
    logic          w_speed_change;

    // Always the reload for the live selection: on a speed change this is
    // the new rate, otherwise it equals the registered rate anyway.
    assign w_reload       = CW'(reload_cycles(speed_sel, CLK_HZ));
    assign w_speed_change = (speed_sel != r_speed);

    // ------------------------------------------------------------------
    // RUN/PAUSE state machine
    // ------------------------------------------------------------------
    run_state_t r_state;
    run_state_t w_state_next;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (w_pause_press) w_state_next = ST_PAUSE;
            ST_PAUSE: if (w_pause_press) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // A step press only matters while paused.
    logic w_step_ok;
`ifdef RATE_TICK_SINGLE_STEP_EN
    assign w_step_ok = (r_state == ST_PAUSE) && w_btn_fall[BTN_STEP];
`else
    assign w_step_ok = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Down-counter
    // ------------------------------------------------------------------
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_count_zero;

    assign w_count_zero = (r_count == '0);

    always_comb begin
        w_count_next = r_count;
        if (w_speed_change) begin
            // Speed change has priority over expiry and over a step.
            w_count_next = w_reload;
        end else if (r_state == ST_RUN) begin
            if (w_count_zero) begin
                w_count_next = w_reload;
            end else begin
                w_count_next = r_count - CW'(1);
            end
        end else if (w_step_ok) begin
            w_count_next = w_reload;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_count <= w_reload;
            r_speed <= speed_sel;
        end else begin
            r_count <= w_count_next;
            r_speed <= speed_sel;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from the pre-toggle state of this cycle)
    // ------------------------------------------------------------------
    always_comb begin
        running = (r_state == ST_RUN);
        tick    = 1'b0;
        if (!reset && !w_speed_change) begin
            tick = ((r_state == ST_RUN) && w_count_zero) || w_step_ok;
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_rate_tick_gen
// Directed bench for rate_tick_gen with CLK_HZ=8, DEBOUNCE_CYCLES=4.
// Reload values: 00 -> 7, 01 -> 3, 10 -> 1, 11 -> 15.
// Inputs are driven right after a falling edge, outputs are sampled on the
// falling edge. A button press driven at a falling edge is first sampled at
// the next rising edge; 2 sync flops + 4 debounce cycles + pulse register +
// state register put the running change 7 falling edges later.
// Optional feature macro: RATE_TICK_SINGLE_STEP_EN (adds step_btn tests).
// ----------------------------------------------------------------------------
module tb_rate_tick_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] speed_sel;
    logic       pause_btn;
`ifdef RATE_TICK_SINGLE_STEP_EN
    logic       step_btn;
`endif
    logic       tick;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rate_tick_gen #(
        .CLK_HZ          (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .speed_sel (speed_sel),
        .pause_btn (pause_btn),
`ifdef RATE_TICK_SINGLE_STEP_EN
        .step_btn  (step_btn),
`endif
        .tick      (tick),
        .running   (running)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Falling edges until the next tick (bounded; a timeout returns 100).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 100);
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tick) cnt++;
        end
    endtask

    // Press pause and wait (bounded) until running reaches exp_run.
    task automatic press_until(input logic exp_run, output int k);
        pause_btn = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (running !== exp_run && k < 20);
    endtask

    initial begin
        int n;
        int k;

        reset     = 1'b1;
        speed_sel = 2'b00;
        pause_btn = 1'b1;
`ifdef RATE_TICK_SINGLE_STEP_EN
        step_btn  = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_running", running, 1);
        check_eq("rst_tick", tick, 0);

        // Reload cycle (count 7) is the first of eight cycles to the tick.
        reset = 1'b0;
        wait_tick(n);
        check_eq("first_tick_1hz", n + 1, 8);
        wait_tick(n);
        check_eq("period_1hz_a", n, 8);
        wait_tick(n);
        check_eq("period_1hz_b", n, 8);

        speed_sel = 2'b10;
        wait_tick(n);
        check_eq("period_4hz_a", n, 2);
        wait_tick(n);
        check_eq("period_4hz_b", n, 2);

        speed_sel = 2'b11;
        wait_tick(n);
        check_eq("period_half_a", n, 16);
        wait_tick(n);
        check_eq("period_half_b", n, 16);

        speed_sel = 2'b00;
        wait_tick(n);
        check_eq("period_1hz_c", n, 8);

        // Change 00 -> 01 while the counter holds 5: reload 3 -> tick 4 later.
        repeat (3) @(negedge clk);
        speed_sel = 2'b01;
        #1;
        check_eq("chg_cycle_tick", tick, 0);
        wait_tick(n);
        check_eq("chg_next_tick", n, 4);

        // Change in the count==0 cycle: change wins, no tick, reload 7.
        speed_sel = 2'b00;
        #1;
        check_eq("chg_wins_tick", tick, 0);
        wait_tick(n);
        check_eq("chg_wins_next", n, 8);

        // Three low samples are one short of the debounce window.
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("glitch3_running", running, 1);

        // 3 low, 1 high, 3 low: the high sample restarts the count.
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("glitch_restart_running", running, 1);

        // Pause pressed in a tick cycle; counter is 1 when PAUSE starts.
        wait_tick(n);
        press_until(1'b0, k);
        check_eq("pause_latency", k, 7);
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        count_ticks(24, n);
        check_eq("pause_no_ticks", n, 0);
        check_eq("pause_release_ignored", running, 0);

        // Resume: held count 1 -> no tick in first RUN cycle, tick in second.
        press_until(1'b1, k);
        check_eq("resume_latency", k, 7);
        check_eq("resume_first_tick", tick, 0);
        @(negedge clk);
        check_eq("resume_held_tick", tick, 1);
        pause_btn = 1'b1;
        wait_tick(n);
        check_eq("resume_period", n, 8);
        check_eq("release_keeps_run", running, 1);

`ifdef RATE_TICK_SINGLE_STEP_EN
        // Step press in RUN: cadence unchanged.
        step_btn = 1'b0;
        wait_tick(n);
        check_eq("step_run_period_a", n, 8);
        step_btn = 1'b1;
        wait_tick(n);
        check_eq("step_run_period_b", n, 8);

        // Step press in PAUSE: exactly one tick.
        press_until(1'b0, k);
        check_eq("step_pause_latency", k, 7);
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        repeat (10) @(negedge clk);
        step_btn = 1'b0;
        count_ticks(16, n);
        check_eq("step_pause_ticks", n, 1);
        step_btn = 1'b1;
        count_ticks(12, n);
        check_eq("step_release_ticks", n, 0);
        check_eq("step_pause_running", running, 0);
        press_until(1'b1, k);
        check_eq("step_resume_latency", k, 7);
        pause_btn = 1'b1;
`endif

        // Reset while paused and mid-debounce of a further press.
        repeat (10) @(negedge clk);
        press_until(1'b0, k);
        check_eq("pause_again_latency", k, 7);
        repeat (3) @(negedge clk);
        pause_btn = 1'b1;
        repeat (10) @(negedge clk);
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        pause_btn = 1'b1;
        @(negedge clk);
        check_eq("rst_pause_running", running, 1);
        check_eq("rst_pause_tick", tick, 0);
        reset = 1'b0;
        wait_tick(n);
        check_eq("rst_pause_first_tick", n + 1, 8);
        repeat (10) @(negedge clk);
        check_eq("rst_debounce_cleared", running, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
